// File: rtl/bin_ascii_conv_pkg.sv
// ---------------------------------------------------------------------------
// bin_ascii_conv_pkg : shared display constants and converter state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bin_ascii_conv_pkg;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_DASH  = 8'h2D;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bin_ascii_conv_bcd_digit_adj3.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj3 : single BCD digit "if >= 5 add 3" correction cell
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_adj3 (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin_ascii_conv.sv
// ---------------------------------------------------------------------------
// bin_ascii_conv : sequential double-dabble binary to decimal ASCII converter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin_ascii_conv
   import bin_ascii_conv_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4,
   parameter int BLANK  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [8*DIGITS-1:0]   ascii_out,
   output logic                  overflow
);

   localparam int BCD_W = 4 * (DIGITS + 1);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      shift_q, shift_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [8*DIGITS-1:0]   ascii_q, ascii_d;
   logic                  overflow_q, overflow_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [BCD_W-1:0]      bcd_adj;
   logic [8*DIGITS-1:0]   ascii_fmt;
   logic                  overflow_fmt;
   logic                  lead;

   // One extra digit beyond DIGITS exists purely to detect overflow.
   generate
      for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
         bcd_digit_adj3 u_adj (
            .digit_in  (bcd_q[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   always_comb begin
      ascii_fmt = '0;
      lead      = (BLANK != 0);
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (lead && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
            ascii_fmt[8*i +: 8] = CH_SPACE;
         end else begin
            ascii_fmt[8*i +: 8] = CH_ZERO + {4'd0, bcd_q[4*i +: 4]};
            lead                = 1'b0;
         end
      end
      overflow_fmt = (bcd_q[BCD_W-1 -: 4] != 4'd0);
      if (overflow_fmt) begin
         ascii_fmt = {DIGITS{CH_DASH}};
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ascii_d    = ascii_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      // busy drops one cycle after the done pulse unless a new start lands then.
      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d = bin_in;
               bcd_d   = '0;
               cnt_d   = CNT_LOAD;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            cnt_d            = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ascii_d    = ascii_fmt;
            overflow_d = overflow_fmt;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ascii_q    <= {DIGITS{CH_SPACE}};
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ascii_q    <= ascii_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign ascii_out = ascii_q;
   assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_ascii_conv.sv
// ---------------------------------------------------------------------------
// tb_bin_ascii_conv : directed self-checking bench for bin_ascii_conv
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bin_ascii_conv;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin_in;
   logic        busy,  done,  overflow;
   logic [31:0] ascii_out;
   logic        busy0, done0, overflow0;
   logic [31:0] ascii0;

   int errors = 0;
   int checks = 0;

   bin_ascii_conv #(.WIDTH(14), .DIGITS(4), .BLANK(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bin_in    (bin_in),
      .busy      (busy),
      .done      (done),
      .ascii_out (ascii_out),
      .overflow  (overflow)
   );

   bin_ascii_conv #(.WIDTH(14), .DIGITS(4), .BLANK(0)) dut_noblank (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bin_in    (bin_in),
      .busy      (busy0),
      .done      (done0),
      .ascii_out (ascii0),
      .overflow  (overflow0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One conversion: checks latency, busy window, output stability, result and single done.
   task automatic conv(input string tag, input logic [13:0] v, input logic [31:0] exp_a,
                       input logic exp_ov, input bit chk_nb, input logic [31:0] exp_nb,
                       input bit inject);
      int          lat;
      int          extra;
      bit          busy_ok;
      bit          hold_ok;
      logic [31:0] prev;
      lat     = 0;
      extra   = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      prev    = ascii_out;
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (inject && n == 5) begin
            start  = 1'b1;
            bin_in = 14'd55;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = n;
            break;
         end
         if (ascii_out !== prev) hold_ok = 1'b0;
      end
      bin_in = 14'd0;
      check({tag, " latency"}, 32'(lat), 32'd15);
      check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " ascii stable"}, {31'd0, hold_ok}, 32'd1);
      check({tag, " ascii"}, ascii_out, exp_a);
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ov});
      if (chk_nb) check({tag, " ascii noblank"}, ascii0, exp_nb);
      @(posedge clk);
      #1;
      check({tag, " done width"}, {31'd0, done}, 32'd0);
      check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) extra++;
      end
      check({tag, " extra done"}, 32'(extra), 32'd0);
      check({tag, " ascii kept"}, ascii_out, exp_a);
   endtask

   initial begin
      int prev_c;
      int ndone;
      int late;

      rst    = 1'b1;
      start  = 1'b0;
      bin_in = 14'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset ascii", ascii_out, 32'h20202020);
      check("reset overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      conv("v1234",  14'd1234,  32'h31323334, 1'b0, 1'b1, 32'h31323334, 1'b0);
      conv("v7",     14'd7,     32'h20202037, 1'b0, 1'b1, 32'h30303037, 1'b0);
      conv("v0",     14'd0,     32'h20202030, 1'b0, 1'b1, 32'h30303030, 1'b0);
      conv("v305",   14'd305,   32'h20333035, 1'b0, 1'b1, 32'h30333035, 1'b0);
      conv("v9999",  14'd9999,  32'h39393939, 1'b0, 1'b0, 32'h0,        1'b0);
      conv("v10000", 14'd10000, 32'h2D2D2D2D, 1'b1, 1'b1, 32'h2D2D2D2D, 1'b0);
      conv("v16383", 14'd16383, 32'h2D2D2D2D, 1'b1, 1'b0, 32'h0,        1'b0);
      conv("ignore", 14'd1234,  32'h31323334, 1'b0, 1'b0, 32'h0,        1'b1);

      // Start held high: accepted at edge 1, then every 16 edges.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 14'd100;
      prev_c = -1;
      ndone  = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (prev_c < 0) check("held first done", 32'(c), 32'd16);
            else            check("held period", 32'(c - prev_c), 32'd16);
            prev_c = c;
            ndone++;
         end
      end
      start = 1'b0;
      check("held done count", 32'(ndone), 32'd3);
      check("held ascii", ascii_out, 32'h20313030);
      repeat (30) @(posedge clk);

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 14'd1234;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      check("midrst ascii", ascii_out, 32'h20202020);
      check("midrst overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      late = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) late++;
      end
      check("midrst no resume", 32'(late), 32'd0);

      conv("v42", 14'd42, 32'h20203432, 1'b0, 1'b1, 32'h30303432, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
